// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul read-side sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN, WAITLOW} ctrl_state_t;

    // Memory read (1) + MAC operand register (1)
    localparam int PIPE_LAT = 2;

    typedef struct packed {
        logic issue;
        logic is_first;
        logic is_last;
    } pipe_tok_t;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int k_bits(input int maxk);
        return clog2_min1(maxk + 1);
    endfunction

    function automatic int a_addr_bits(input int m, input int maxk);
        return clog2_min1(m * maxk);
    endfunction

    function automatic int b_addr_bits(input int maxk, input int n);
        return clog2_min1(maxk * n);
    endfunction

endpackage

// File: rtl/ctrl_valid_pipe.sv
// Delays issue tokens to line up with memory read data: stage 1 drives the MAC
// strobes, the last stage flags a finished accumulator.
module ctrl_valid_pipe
    import matmul_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  pipe_tok_t tok_i,
    output logic      mac_en_o,
    output logic      mac_init_o,
    output logic      result_valid_o
);

    pipe_tok_t [PIPE_LAT:1] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pipe_q <= '0;
        else         pipe_q <= {pipe_q[PIPE_LAT-1:1], tok_i};
    end

    assign mac_en_o       = pipe_q[1].issue;
    assign mac_init_o     = pipe_q[1].issue & pipe_q[1].is_first;
    assign result_valid_o = pipe_q[PIPE_LAT].issue & pipe_q[PIPE_LAT].is_last;

endmodule

// File: rtl/matmul_ctrl.sv
// Read-side sequencer for C = A*B: walks C row-major, issues K address pairs per
// element. Optional busy-cycle counter enabled by MATMUL_CTRL_PERF_EN.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter  int M           = 7,
    parameter  int N           = 9,
    parameter  int MAXK        = 8,
    localparam int K_BITS      = k_bits(MAXK),
    localparam int A_ADDR_BITS = a_addr_bits(M, MAXK),
    localparam int B_ADDR_BITS = b_addr_bits(MAXK, N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   matrices_loaded,
    input  logic [K_BITS-1:0]      K,
    output logic [A_ADDR_BITS-1:0] A_read_addr,
    output logic [B_ADDR_BITS-1:0] B_read_addr,
    input  logic                   fifo_has_space,
    output logic                   mac_en,
    output logic                   mac_init,
    output logic                   result_valid,
    output logic                   compute_finished,
    output logic [31:0]            busy_cycles
);

    localparam int IW = clog2_min1(M);
    localparam int JW = clog2_min1(N);

    ctrl_state_t            state_q, state_d;
    logic [K_BITS-1:0]      k_lat_q, k_lat_d, k_q, k_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [A_ADDR_BITS-1:0] a_base_q, a_base_d, a_addr_q, a_addr_d;
    logic [B_ADDR_BITS-1:0] b_addr_q, b_addr_d;
    logic                   issue, first_term, last_term;
    pipe_tok_t              tok;

    assign first_term = (k_q == '0);
    assign last_term  = (k_q == k_lat_q - K_BITS'(1));

    always_comb begin
        state_d  = state_q;
        k_lat_d  = k_lat_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        a_base_d = a_base_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: if (matrices_loaded) begin
                k_lat_d  = K;
                k_d      = '0;
                i_d      = '0;
                j_d      = '0;
                a_base_d = '0;
                a_addr_d = '0;
                b_addr_d = '0;
                state_d  = (K == '0) ? FIN : RUN;
            end
            RUN: begin
                // Backpressure only gates the start of an element, never mid-element
                issue = first_term ? fifo_has_space : 1'b1;
                if (issue) begin
                    if (!last_term) begin
                        k_d      = k_q + K_BITS'(1);
                        a_addr_d = a_addr_q + A_ADDR_BITS'(1);
                        b_addr_d = b_addr_q + B_ADDR_BITS'(N);
                    end else begin
                        k_d = '0;
                        if (j_q != JW'(N - 1)) begin
                            j_d      = j_q + JW'(1);
                            a_addr_d = a_base_q;
                            b_addr_d = B_ADDR_BITS'(j_q) + B_ADDR_BITS'(1);
                        end else begin
                            j_d      = '0;
                            b_addr_d = '0;
                            if (i_q != IW'(M - 1)) begin
                                i_d      = i_q + IW'(1);
                                a_base_d = a_base_q + A_ADDR_BITS'(k_lat_q);
                                a_addr_d = a_base_q + A_ADDR_BITS'(k_lat_q);
                            end else begin
                                i_d      = '0;
                                a_base_d = '0;
                                a_addr_d = '0;
                                state_d  = DRAIN;
                            end
                        end
                    end
                end
            end
            // A result with stage 1 empty can only be the final element
            DRAIN:   if (result_valid && !mac_en) state_d = FIN;
            FIN:     state_d = WAITLOW;
            WAITLOW: if (!matrices_loaded) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            k_lat_q  <= '0;
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            a_base_q <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            k_lat_q  <= k_lat_d;
            k_q      <= k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            a_base_q <= a_base_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
        end
    end

    assign tok = {issue, first_term, last_term};

    ctrl_valid_pipe u_pipe (
        .clk_i          (clk),
        .rst_ni         (reset),
        .tok_i          (tok),
        .mac_en_o       (mac_en),
        .mac_init_o     (mac_init),
        .result_valid_o (result_valid)
    );

    assign A_read_addr      = a_addr_q;
    assign B_read_addr      = b_addr_q;
    assign compute_finished = (state_q == FIN);

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (state_q == IDLE && state_d == RUN)
            busy_d = '0;
        else if ((state_q == RUN || state_q == DRAIN) && busy_q != '1)
            busy_d = busy_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed + randomized bench for matmul_ctrl; a negedge monitor checks every
// MAC term against the row-major index arithmetic of C = A*B.
module tb_matmul_ctrl;

    localparam int M    = 7;
    localparam int N    = 9;
    localparam int MAXK = 8;
    localparam int KB   = $clog2(MAXK + 1);
    localparam int AW   = $clog2(M * MAXK);
    localparam int BW   = $clog2(MAXK * N);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ml = 1'b0;
    logic          fifo = 1'b1;
    logic [KB-1:0] K = '0;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic          mac_en, mac_init, result_valid, compute_finished;
    logic [31:0]   busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int       k_cur, term_idx, rv_cnt, fin_cnt, first_issue, first_rv, last_rv, fin_cyc;
    bit       mon_on = 1'b0;
    bit       exp_rv, prev_en;
    logic [AW-1:0] prev_A;
    logic [BW-1:0] prev_B;

    matmul_ctrl #(.M(M), .N(N), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (ml),
        .K                (K),
        .A_read_addr      (A),
        .B_read_addr      (B),
        .fifo_has_space   (fifo),
        .mac_en           (mac_en),
        .mac_init         (mac_init),
        .result_valid     (result_valid),
        .compute_finished (compute_finished),
        .busy_cycles      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mon_clear(input int kk);
        k_cur       = kk;
        term_idx    = 0;
        rv_cnt      = 0;
        fin_cnt     = 0;
        first_issue = -1;
        first_rv    = -1;
        last_rv     = -1;
        fin_cyc     = -1;
        exp_rv      = 1'b0;
        prev_en     = 1'b0;
        mon_on      = 1'b1;
    endtask

    // Term n of a run: element e = n/K -> (i, j) = (e/N, e%N), k = n%K
    task automatic monitor();
        int kk, e, ii, jj;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("rv_align", result_valid, exp_rv);
                exp_rv = 1'b0;
                if (mac_en) begin
                    if (k_cur == 0) begin
                        chk("en_with_k0", mac_en, 0);
                    end else begin
                        kk = term_idx % k_cur;
                        e  = term_idx / k_cur;
                        ii = e / N;
                        jj = e % N;
                        chk("a_addr", prev_A, ii * k_cur + kk);
                        chk("b_addr", prev_B, kk * N + jj);
                        chk("mac_init", mac_init, kk == 0);
                        if (kk != 0) chk("contiguous", prev_en, 1);
                        if (kk == k_cur - 1) exp_rv = 1'b1;
                        if (term_idx == 0) first_issue = cyc - 1;
                    end
                    term_idx++;
                end else begin
                    chk("init_no_en", mac_init, 0);
                end
                if (result_valid) begin
                    if (rv_cnt == 0) first_rv = cyc;
                    rv_cnt++;
                    last_rv = cyc;
                end
                if (compute_finished) begin
                    fin_cnt++;
                    fin_cyc = cyc;
                end
            end
            prev_A  = A;
            prev_B  = B;
            prev_en = mac_en;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_B"}, B, 0);
        chk({tag, "_en"}, mac_en, 0);
        chk({tag, "_init"}, mac_init, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_fin"}, compute_finished, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // se/sl: element index to stall before and bubble length (se<0: none)
    task automatic run(input int kk, input int se, input int sl, input int hold, input bit rnd);
        int drive, stalls;
        bit done;
        mon_clear(kk);
        K      = KB'(kk);
        fifo   = 1'b1;
        ml     = 1'b1;
        drive  = cyc;
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (fin_cnt > 0) begin
                done = 1'b1;
                break;
            end
            if (se >= 0 && term_idx == se * kk && stalls < sl) begin
                fifo = 1'b0;
                stalls++;
                chk("hold_a", A, (se / N) * kk);
                chk("hold_b", B, se % N);
            end else begin
                fifo = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        fifo = 1'b1;
        chk("finished", done, 1);
        repeat (hold) tick();
        chk("mac_cnt", term_idx, M * N * kk);
        chk("rv_cnt", rv_cnt, (kk == 0) ? 0 : M * N);
        chk("fin_cnt", fin_cnt, 1);
        if (kk == 0) begin
            chk("fin_k0", fin_cyc, drive + 1);
        end else begin
            chk("last_rv", last_rv, fin_cyc - 1);
            if (!rnd) begin
                chk("first_issue", first_issue, drive + 1);
                chk("fin_cyc", fin_cyc, drive + 1 + M * N * kk + 2 + sl);
            end
        end
`ifdef MATMUL_CTRL_PERF_EN
        if (kk > 0) chk("busy", busy, fin_cyc - drive - 1);
`else
        chk("busy", busy, 0);
`endif
        ml = 1'b0;
        tick();
        tick();
        chk("fin_low", compute_finished, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // Full K=8 run, no backpressure: 504 terms, finish 506 after first issue
        run(8, -1, 0, 0, 1'b0);

        // K=1: every term is first and last, results back-to-back
        run(1, -1, 0, 0, 1'b0);
        chk("k1_b2b", last_rv - first_rv, M * N - 1);

        // K=3, 4-cycle bubble before element 5
        run(3, 5, 4, 0, 1'b0);

        // K=0 with the level held: no work, no restart while held
        run(0, -1, 0, 10, 1'b0);
        run(2, -1, 0, 0, 1'b0);

        // Randomized K and backpressure
        for (int r = 0; r < 3; r++) run(int'($urandom_range(1, MAXK)), -1, 0, 0, 1'b1);

        // Abort mid-run
        mon_clear(8);
        K  = KB'(8);
        ml = 1'b1;
        repeat (100) tick();
        mon_on = 1'b0;
        reset  = 1'b0;
        #1;
        check_zero("rst_mid");
        ml = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        mon_clear(8);
        repeat (5) tick();
        chk("idle_no_en", mac_en, 0);
        chk("idle_no_fin", fin_cnt, 0);
        run(8, -1, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
Sequencer that drives the read side of the A/B input memories and the MAC datapath for C = A·B.
- A is MxK, stored row-major at address i*K+k; B is KxN, stored row-major at address k*N+j.
- Starts when the memories report matrices loaded, walks all M*N output elements in row-major order and issues K address pairs per element.
- Emits aligned MAC enable/init strobes, applies output backpressure, and returns compute_finished to the memory block.

Parameters:
M, 7, rows of A / rows of C
N, 9, columns of B / columns of C
MAXK, 8, maximum shared dimension K
K_BITS, $clog2(MAXK+1), localparam, width of K
A_ADDR_BITS, $clog2(M*MAXK), localparam, A address width
B_ADDR_BITS, $clog2(MAXK*N), localparam, B address width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
matrices_loaded  in  1  level; A and B are valid in memory
K  in  K_BITS  shared dimension; sampled only on start
A_read_addr  out  A_ADDR_BITS  A memory read address
B_read_addr  out  B_ADDR_BITS  B memory read address
fifo_has_space  in  1  output FIFO can absorb at least 2 more results
mac_en  out  1  A_data/B_data valid this cycle; accumulate
mac_init  out  1  with mac_en: first term; load the product instead of adding it
result_valid  out  1  MAC accumulator holds a finished C element
compute_finished  out  1  one-cycle pulse; all M*N results delivered
busy_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; addresses 0; internal counters i, j, k = 0.
- States:
  - IDLE → RUN when matrices_loaded==1; latch K into k_lat.
  - IDLE → FIN instead if the latched K==0: no issue, no result_valid.
  - RUN: issue one address pair per cycle.
  - DRAIN: wait for the 2-stage pipeline to empty.
  - FIN: compute_finished=1 for exactly one cycle → WAITLOW.
  - WAITLOW: hold until matrices_loaded==0, then → IDLE. This prevents a restart on the stale level.
- Addressing uses no multiplier:
  - a_row_base += k_lat per row; A_read_addr = a_row_base + k.
  - B_read_addr starts at j and steps by N per k.
  - Addresses are registered outputs, valid in the cycle they are issued.
- Issue gating:
  - At k==0, an element starts only if fifo_has_space==1; otherwise a bubble (no issue, addresses held).
  - Once started, an element's K terms issue on consecutive cycles and are never interrupted.
- Pipeline latency (memory read is 1 cycle):
  - Issue in cycle t → mac_en (and mac_init when k==0) in cycle t+1, aligned with A_data/B_data.
  - The last term (k==k_lat-1) issued in t → result_valid in t+2.
- Counters:
  - k wraps to 0 after k_lat-1; j increments.
  - j wraps after N-1; i increments and a_row_base advances.
  - After i==M-1, j==N-1, k==k_lat-1 is issued → DRAIN.
- DRAIN → FIN in the cycle after the final result_valid.
- No-stall timing, with first issue in cycle 0: last result_valid at cycle M*N*K+1; compute_finished at M*N*K+2.
- matrices_loaded dropping during RUN/DRAIN is ignored; the operation completes.
- Reset asserted mid-operation aborts immediately; in-flight results are discarded and no compute_finished is produced.

Optional Feature:
- Macro: MATMUL_CTRL_PERF_EN.
- With it: busy_cycles clears on IDLE→RUN and increments every cycle in RUN and DRAIN, including stall bubbles. It holds its value through FIN, WAITLOW and IDLE, and saturates at 2^32-1.
- Without it: busy_cycles is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package matmul_pkg holds:
  - ctrl_state_t enum {IDLE, RUN, DRAIN, FIN, WAITLOW};
  - PIPE_LAT=2 constant;
  - width helper functions for K_BITS, A_ADDR_BITS and B_ADDR_BITS.
- One sub-module, ctrl_valid_pipe: a 2-stage shift register carrying {issue, first, last} to produce mac_en, mac_init and result_valid.

Test Plan:
- M=7, N=9, K=8, fifo_has_space=1 → 504 mac_en pulses and 63 result_valid pulses.
  - First element addresses: A 0..7 and B 0,9,...,63.
  - Last result_valid at cycle 505; compute_finished pulse at cycle 506.
- K=1 → A_read_addr = i and B_read_addr = j for each element; every mac_en has mac_init=1; 63 results back-to-back.
- K=3, fifo_has_space low at the start of element 5 for 4 cycles → 4-cycle bubble with addresses held and mac_en=0; the element is not split; result count is still 63.
- K=0 with matrices_loaded=1 → no mac_en or result_valid; compute_finished one cycle after start.
  - Controller then stays in WAITLOW until matrices_loaded drops.
- matrices_loaded held high for 10 cycles after compute_finished → no restart.
  - Drop it, then raise it again with K=2 → a new run begins.
- reset pulsed low at cycle 100 of a K=8 run → all outputs 0 immediately.
  - After release, the controller waits in IDLE until matrices_loaded is seen high, then starts a full run.
- With MATMUL_CTRL_PERF_EN, K=8 and no stalls → busy_cycles=506 after finish.
  - Without the macro, busy_cycles stays 0.
